bs_gnrtr_n_rbtr_rr: RTL and testbench

- Parametrised successor to the single-mode bus generator/arbiter: serves DRVRS FIFO-style device ports over one shared bus.
- Picks one pending device (round-robin or fixed priority), pops its head packet, and pushes it to the destination device or broadcasts it.
- Decodes the destination from the packet header, counts dropped/invalid packets, and sits between the per-device FIFO interfaces and the bench agents.

---
 rtl/bs_gnrtr_n_rbtr_rr_pkg.sv | 27 ++
 rtl/bs_gnrtr_n_rbtr_rr_arb.sv | 43 ++++
 rtl/bs_gnrtr_n_rbtr_rr.sv | 130 +++++++++++++
 tb/tb_bs_gnrtr_n_rbtr_rr.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bs_gnrtr_n_rbtr_rr_pkg.sv
// Shared definitions for the bus generator / arbiter.
//   state_e    : transaction FSM states (IDLE -> POP -> PUSH -> IDLE)
//   ARB_RR     : round-robin arbitration mode
//   ARB_FIXED  : fixed priority, lowest index wins
//   dest_field : pulls the destination-ID field (top id_w bits) out of a packet
package bs_rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Packets up to 64 bits are supported. The caller zero-extends the packet
  // into the 64-bit argument, so the ID field sits at bits [pkt_sz-1 -: id_w].
  function automatic logic [31:0] dest_field(input logic [63:0] pkt,
                                             input int pkt_sz,
                                             input int id_w);
    logic [63:0] mask;
    mask = (64'd1 << id_w) - 64'd1;
    return 32'((pkt >> (pkt_sz - id_w)) & mask);
  endfunction

endpackage

// File: rtl/bs_gnrtr_n_rbtr_rr_arb.sv
// Purely combinational request arbiter.
//   req_i   : per-device request vector
//   ptr_i   : round-robin start index (ignored in fixed-priority mode)
//   grant_o : index of the winning request
//   valid_o : high when any request is set
module rr_arbiter
  import bs_rr_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = ARB_RR,
  parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  always_comb begin
    int          idx;
    logic [N-1:0] rot;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    rot     = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_FIXED) begin
        idx = k;
      end else begin
        // Cyclic search starting at the pointer; explicit wrap keeps this
        // correct when N is not a power of two.
        idx = int'(ptr_i) + k;
        if (idx >= N) idx = idx - N;
      end
      rot = req_i >> idx;
      if (!valid_o && rot[0]) begin
        valid_o = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bs_gnrtr_n_rbtr_rr.sv
// Shared-bus packet mover: arbitrates between DRVRS device FIFOs, pops the
// granted head packet and pushes it to its destination device (or to every
// other device on broadcast). Undeliverable packets are dropped and counted.
//   clk, reset  : clock, asynchronous active-high reset
//   pndng       : per-device "FIFO non-empty"
//   D_pop       : per-device head-of-FIFO data
//   pop         : one-hot dequeue pulse to the granted device
//   push        : per-device enqueue pulse
//   D_push      : latched packet, replicated on every lane
//   drop        : pulse when a packet is discarded
//   drop_cnt    : saturating drop counter
//   busy        : FSM not in IDLE
//   dbg_state_o : raw FSM state
//
// Handshake: pop is the only dequeue strobe; the source must present valid
// D_pop for the granted device in the cycle pop is high. push is a fire-and-
// forget enqueue strobe with D_push valid in the same cycle; there is no
// backpressure from the destination.
module bs_gnrtr_n_rbtr_rr
  import bs_rr_pkg::*;
#(
  parameter int          PCKG_SZ  = 16,
  parameter int          DRVRS    = 8,
  parameter int          ID_W     = 8,
  parameter int unsigned BCAST_ID = 32'hFF,
  parameter int          ARB_MODE = ARB_RR,
  parameter int          CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic                            drop,
  output logic [CNT_W-1:0]                drop_cnt,
  output logic                            busy,
  output logic [1:0]                      dbg_state_o
);

  localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [DRVRS-1:0] ONE = DRVRS'(1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   arb_grant;
  logic               arb_valid;
  logic [31:0]        dest;

  rr_arbiter #(
    .N    (DRVRS),
    .MODE (ARB_MODE),
    .IW   (PTR_W)
  ) u_arb (
    .req_i   (pndng),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      pkt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    pop     = '0;
    push    = '0;
    drop    = 1'b0;
    dest    = dest_field(64'(pkt_q), PCKG_SZ, ID_W);
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = POP;
        end
      end
      POP: begin
        // Pop is issued even if pndng has fallen; underflow is the source's
        // problem and we latch whatever D_pop shows.
        pop   = ONE << grant_q;
        pkt_d = D_pop[grant_q];
        if (ARB_MODE == ARB_RR) begin
          ptr_d = (grant_q == PTR_W'(DRVRS - 1)) ? '0 : grant_q + 1'b1;
        end
        state_d = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
        if (dest == BCAST_ID) begin
          push = ~(ONE << grant_q);
        end else if (dest < 32'(DRVRS) && dest != 32'(grant_q)) begin
          push = ONE << dest;
        end else begin
          // Out-of-range destination or a packet addressed to its own source.
          drop = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign D_push      = {DRVRS{pkt_q}};
  assign drop_cnt    = cnt_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr_rr.sv
module tb_bs_gnrtr_n_rbtr_rr;

  logic clk;
  logic reset;

  // Round-robin instance
  logic [7:0]        pndng_rr;
  logic [7:0][15:0]  d_pop_rr;
  logic [7:0]        pop_rr, push_rr;
  logic [7:0][15:0]  d_push_rr;
  logic              drop_rr, busy_rr;
  logic [15:0]       drop_cnt_rr;
  logic [1:0]        state_rr;

  // Fixed-priority instance
  logic [7:0]        pndng_fp;
  logic [7:0][15:0]  d_pop_fp;
  logic [7:0]        pop_fp, push_fp;
  logic [7:0][15:0]  d_push_fp;
  logic              drop_fp, busy_fp;
  logic [15:0]       drop_cnt_fp;
  logic [1:0]        state_fp;

  int checks = 0;
  int errors = 0;

  logic [15:0] pk [8];
  logic [7:0]  pexp [8];

  bs_gnrtr_n_rbtr_rr #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .pndng(pndng_rr), .D_pop(d_pop_rr),
    .pop(pop_rr), .push(push_rr), .D_push(d_push_rr), .drop(drop_rr),
    .drop_cnt(drop_cnt_rr), .busy(busy_rr), .dbg_state_o(state_rr)
  );

  bs_gnrtr_n_rbtr_rr #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng_fp), .D_pop(d_pop_fp),
    .pop(pop_fp), .push(push_fp), .D_push(d_push_fp), .drop(drop_fp),
    .drop_cnt(drop_cnt_fp), .busy(busy_fp), .dbg_state_o(state_fp)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer on the round-robin instance from a single source.
  task automatic run_txn(input logic [2:0] dev, input logic [15:0] pkt,
                         input logic [7:0] exp_push, input logic exp_drop);
    d_pop_rr[dev] = pkt;
    pndng_rr      = 8'd1 << dev;
    step();
    chk($sformatf("pop_d%0d", dev), pop_rr, 8'd1 << dev);
    chk($sformatf("nopush_in_pop_d%0d", dev), push_rr, 8'h00);
    chk($sformatf("busy_pop_d%0d", dev), busy_rr, 1'b1);
    pndng_rr = 8'h00;
    step();
    chk($sformatf("push_d%0d", dev), push_rr, exp_push);
    chk($sformatf("dpush_d%0d", dev), d_push_rr, {8{pkt}});
    chk($sformatf("drop_d%0d", dev), drop_rr, exp_drop);
    chk($sformatf("nopop_in_push_d%0d", dev), pop_rr, 8'h00);
    step();
    chk($sformatf("idle_d%0d", dev), busy_rr, 1'b0);
    chk($sformatf("idle_drop_d%0d", dev), drop_rr, 1'b0);
  endtask

  initial begin
    int gseq [4];
    int fseq [3];
    reset    = 1'b1;
    pndng_rr = '0;
    d_pop_rr = '0;
    pndng_fp = '0;
    d_pop_fp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", pop_rr, 8'h00);
    chk("rst_push", push_rr, 8'h00);
    chk("rst_dpush", d_push_rr, 128'h0);
    chk("rst_drop", drop_rr, 1'b0);
    chk("rst_cnt", drop_cnt_rr, 16'h0);
    chk("rst_busy", busy_rr, 1'b0);
    chk("rst_state", state_rr, 2'd0);
    reset = 1'b0;
    step();
    chk("idle_no_req", busy_rr, 1'b0);

    // Unicast: device 2 -> dest 5
    run_txn(3'd2, 16'h05AB, 8'b0010_0000, 1'b0);
    // Broadcast from device 0
    run_txn(3'd0, 16'hFF12, 8'b1111_1110, 1'b0);
    // Drops: out-of-range dest, then self-addressed
    run_txn(3'd4, 16'h0977, 8'h00, 1'b1);
    chk("drop_cnt_1", drop_cnt_rr, 16'd1);
    run_txn(3'd4, 16'h0488, 8'h00, 1'b1);
    chk("drop_cnt_2", drop_cnt_rr, 16'd2);
    // D_push holds the last latched packet while idle
    chk("dpush_hold", d_push_rr, {8{16'h0488}});

    // Reset during POP
    d_pop_rr[6] = 16'h0101;
    pndng_rr    = 8'h40;
    step();
    chk("mid_pop", pop_rr, 8'h40);
    chk("mid_state_pop", state_rr, 2'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pop", pop_rr, 8'h00);
    chk("mid_rst_busy", busy_rr, 1'b0);
    chk("mid_rst_cnt", drop_cnt_rr, 16'h0);
    step();
    chk("mid_rst_push", push_rr, 8'h00);
    chk("mid_rst_dpush", d_push_rr, 128'h0);
    pndng_rr = 8'h00;
    reset    = 1'b0;
    step();

    // Round-robin among devices 1, 3, 6; pointer must have restarted at 0
    pk[1] = 16'h0211; pexp[1] = 8'b0000_0100;
    pk[3] = 16'h0533; pexp[3] = 8'b0010_0000;
    pk[6] = 16'h0066; pexp[6] = 8'b0000_0001;
    d_pop_rr[1] = pk[1];
    d_pop_rr[3] = pk[3];
    d_pop_rr[6] = pk[6];
    pndng_rr    = 8'b0100_1010;
    gseq = '{1, 3, 6, 1};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_pop_%0d", i), pop_rr, 8'd1 << gseq[i]);
      step();
      chk($sformatf("rr_push_%0d", i), push_rr, pexp[gseq[i]]);
      chk($sformatf("rr_dpush_%0d", i), d_push_rr, {8{pk[gseq[i]]}});
      step();
      chk($sformatf("rr_idle_%0d", i), pop_rr | push_rr, 8'h00);
    end
    pndng_rr = 8'h00;

    // Fixed priority on the second instance
    d_pop_fp[1] = pk[1];
    d_pop_fp[3] = pk[3];
    d_pop_fp[6] = pk[6];
    pndng_fp    = 8'b0100_1010;
    fseq = '{1, 1, 3};
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fp_pop_%0d", i), pop_fp, 8'd1 << fseq[i]);
      if (i == 1) pndng_fp[1] = 1'b0;
      step();
      chk($sformatf("fp_push_%0d", i), push_fp, pexp[fseq[i]]);
      step();
      chk($sformatf("fp_idle_%0d", i), busy_fp, 1'b0);
    end
    pndng_fp = 8'h00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
